cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32 core on the Tang Nano 9k.
- Takes the combinational decode flags (reg_write, mem_read, mem_write, branch, jump) and alu_zero from the datapath.
- Drives one-cycle datapath strobes (ir_we, pc_we, rf_we) and the instruction/data memory request handshakes.
- Sits between the decoder/ALU datapath and the BSRAM memory ports; also owns a memory-timeout watchdog and an instruction counter.

Parameters:
- TIMEOUT_W, 4: width of the memory wait counter.
- MEM_TIMEOUT, 12: ready-wait cycles before entering FAULT; legal range 1 .. 2^TIMEOUT_W-1.
- ICNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; allows a new fetch to start from IDLE.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid only while dmem_req=1.
- dmem_ready  in  1  data access complete this cycle.
- dec_reg_write  in  1  decoder flag.
- dec_mem_read  in  1  decoder flag.
- dec_mem_write  in  1  decoder flag.
- dec_branch  in  1  decoder flag.
- dec_jump  in  1  decoder flag.
- alu_zero  in  1  ALU result == 0.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target.
- rf_we  out  1  register-file write strobe.
- state  out  3  current state encoding.
- fault  out  1  sticky timeout flag.
- icount  out  ICNT_W  retired instructions.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. All transitions occur on the rising clk edge.
- Reset (async, rst_n=0): state=IDLE; fault=0; icount=0; wait counter=0; all strobes and requests 0.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - imem_req=1 for every cycle in this state.
  - imem_ready=1 -> ir_we=1 in that same cycle, then -> DECODE.
  - Otherwise the wait counter increments; counter==MEM_TIMEOUT -> FAULT.
- DECODE: one cycle, no outputs asserted; -> EXEC. The decode flags are sampled combinationally in EXEC.
- EXEC:
  - dec_mem_read or dec_mem_write -> MEM.
  - dec_branch: pc_we=1; pc_sel=alu_zero (beq taken when zero). -> IDLE if run=0, else FETCH; the instruction retires.
  - dec_jump: pc_we=1, pc_sel=1; -> WB, which performs the link write.
  - Otherwise (ALU op): -> WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ready.
  - On dmem_ready: store -> pc_we=1, pc_sel=0, retire, -> FETCH/IDLE; load -> WB.
  - Timeout rules are identical to FETCH.
- WB:
  - rf_we=dec_reg_write.
  - pc_we=1, pc_sel=0, except after a jump, where the PC was already written in EXEC.
  - Retire; -> FETCH if run=1, else IDLE.
- Retire: icount increments by 1 and wraps from 2^ICNT_W-1 to 0. At most one retire per instruction.
- Wait counter: clears on every state entry. Ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success; ready wins.
- FAULT: absorbing. fault=1, all strobes 0. Exit only by reset.
- run deasserted mid-instruction: the current instruction completes, then the block parks in IDLE.
- Output timing: strobes are Moore/Mealy combinational from the registered state and the current inputs, so each is high for exactly one cycle per event.
- Request behaviour: imem_req and dmem_req never assert simultaneously. They drop in the cycle after ready.
- Latencies with zero-wait memory: ALU op 4 cycles (FETCH→WB), load 5, store 4, branch 3.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Enabled: adds input dec_valid (1 bit). In DECODE, dec_valid=0 -> FAULT with fault=1 and a second sticky output illegal=1.
- Disabled: no dec_valid or illegal ports; unknown opcodes fall through EXEC as a no-op ALU op with rf_we=0.

Decomposition:
- Shared package rv_pkg: state encoding localparams, opcode constants, PC_SEL_SEQ/PC_SEL_TGT.
- One sub-module, mem_wait_timer: counter with clear, enable, and a timeout compare, instantiated once and shared by FETCH and MEM.

Test Plan:
- ALU op (addi), run=1, ready on first cycle: states 1→2→3→5; rf_we=1 at cycle 4; pc_we with pc_sel=0; icount=1.
- lw with dmem_ready after 3 wait cycles: MEM lasts 4 cycles, dmem_we=0, rf_we in WB; store variant shows dmem_we=1 and rf_we never asserted.
- beq with alu_zero=1 -> pc_we=1, pc_sel=1 in EXEC, no rf_we; alu_zero=0 -> pc_sel=0.
- imem_ready held 0 -> FAULT after 12 wait cycles, fault=1, sticky; ready arriving on the 12th cycle -> DECODE, no fault.
- rst_n pulsed low mid-MEM -> outputs zero immediately (async), state=IDLE, icount=0.
- icount preloaded via 2^16-1 retires (or force) -> next retire wraps to 0; run dropped during EXEC -> WB then IDLE.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared definitions for the RV32 multi-cycle sequencer:
//               state encodings, RV32I major opcodes and PC-select values.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // State encodings, exposed on the 'state' port of the sequencer
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_FAULT  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_FETCH  = c_ST_FETCH,
        ST_DECODE = c_ST_DECODE,
        ST_EXEC   = c_ST_EXEC,
        ST_MEM    = c_ST_MEM,
        ST_WB     = c_ST_WB,
        ST_FAULT  = c_ST_FAULT
    } state_t;

    // RV32I major opcodes (instruction bits [6:0]), used by the decoder
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // PC source select: sequential (PC+4) or branch/jump target
    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Memory ready-wait counter shared by the FETCH and MEM states.
//               Counts cycles while i_en is high and flags o_expire on the
//               cycle in which the count would reach MEM_TIMEOUT.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               i_clr    - clear the count (state entry)
//               i_en     - a wait cycle is being spent (request, no ready)
//               o_expire - this wait cycle is number MEM_TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    // The count holds the number of wait cycles already completed, so the
    // MEM_TIMEOUT-th wait cycle is the one that sees MEM_TIMEOUT-1.
    localparam logic [TIMEOUT_W-1:0] c_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == c_LAST);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_ctrl
// Description : Multi-cycle sequencer for the single-issue RV32 core.
//               IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB], with a
//               shared memory-timeout watchdog (sticky FAULT) and a
//               retired-instruction counter.
// Ports       : clk, rst_n          - clock / async active-low reset
//               run                 - allow a new fetch from IDLE
//               imem_req/imem_ready - instruction memory handshake
//               dmem_req/dmem_we/dmem_ready - data memory handshake
//               dec_*               - decoder flags, alu_zero from the ALU
//               ir_we/pc_we/pc_sel/rf_we - one-cycle datapath strobes
//               state, fault, icount - status
//               dec_valid, illegal  - present only with ILLEGAL_TRAP_EN
// Build macro : ILLEGAL_TRAP_EN - trap undecodable instructions into FAULT
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl
    import rv_pkg::*;
#(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12,
    parameter int ICNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              dec_reg_write,
    input  logic              dec_mem_read,
    input  logic              dec_mem_write,
    input  logic              dec_branch,
    input  logic              dec_jump,
    input  logic              alu_zero,
`ifdef ILLEGAL_TRAP_EN
    input  logic              dec_valid,
    output logic              illegal,
`endif
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_sel,
    output logic              rf_we,
    output logic [2:0]        state,
    output logic              fault,
    output logic [ICNT_W-1:0] icount
);

    state_t              r_state;
    state_t              w_next;
    logic                r_fault;
    logic                r_jump;
    logic [ICNT_W-1:0]   r_icount;

    logic                w_retire;
    logic                w_tmr_en;
    logic                w_tmr_clr;
    logic                w_expire;
    logic                w_mem_op;
    logic                w_jump_path;
    state_t              w_after_retire;

    // ------------------------------------------------------------------
    // Wait timer: cleared on every state change so FETCH and MEM each
    // start with a fresh budget.
    // ------------------------------------------------------------------
    assign w_tmr_clr = (w_next != r_state);

    mem_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    assign w_mem_op       = dec_mem_read | dec_mem_write;
    // EXEC priority is memory > branch > jump > ALU, so a jump only takes
    // effect when neither of the higher-priority flags is set.
    assign w_jump_path    = dec_jump & ~w_mem_op & ~dec_branch;
    assign w_after_retire = run ? ST_FETCH : ST_IDLE;

    // ------------------------------------------------------------------
    // State register and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_fault  <= 1'b0;
            r_jump   <= 1'b0;
            r_icount <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_FAULT) begin
                r_fault <= 1'b1;
            end
            // Remembers that the PC was already redirected in EXEC, so WB
            // must not overwrite it with PC+4.
            if (r_state == ST_EXEC) begin
                r_jump <= w_jump_path;
            end
            if (w_retire) begin
                r_icount <= r_icount + 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if ((r_state == ST_DECODE) && !dec_valid) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

    // ------------------------------------------------------------------
    // Next state and combinational strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_SEQ;
        rf_we    = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        w_retire = 1'b0;
        w_tmr_en = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    w_next = ST_DECODE;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_expire) begin
                        w_next = ST_FAULT;
                    end
                end
            end

            ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                w_next = dec_valid ? ST_EXEC : ST_FAULT;
`else
                w_next = ST_EXEC;
`endif
            end

            ST_EXEC: begin
                if (w_mem_op) begin
                    w_next = ST_MEM;
                end else if (dec_branch) begin
                    pc_we    = 1'b1;
                    pc_sel   = alu_zero ? PC_SEL_TGT : PC_SEL_SEQ;
                    w_retire = 1'b1;
                    w_next   = w_after_retire;
                end else if (dec_jump) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_SEL_TGT;
                    w_next = ST_WB;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ready) begin
                    if (dec_mem_write) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = w_after_retire;
                    end else begin
                        w_next = ST_WB;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_expire) begin
                        w_next = ST_FAULT;
                    end
                end
            end

            ST_WB: begin
                rf_we    = dec_reg_write;
                pc_we    = ~r_jump;
                w_retire = 1'b1;
                w_next   = w_after_retire;
            end

            ST_FAULT: begin
                w_next = ST_FAULT;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign state  = r_state;
    assign fault  = r_fault;
    assign icount = r_icount;

endmodule : cpu_seq_ctrl
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_seq_ctrl
// Description : Self-checking bench for cpu_seq_ctrl. A driver acts as the
//               decoder and both memories, picks random instructions and
//               pushes the strobe events each one must produce (cycle,
//               state, strobes, icount) into a queue; a monitor pops and
//               compares whenever any strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

    localparam int c_ICNT_W  = 4;     // small so the counter wrap is reached
    localparam int c_TIMEOUT = 12;
    localparam int c_NEVER   = 99;    // wait count that never produces ready
    localparam int c_N_RAND  = 60;

    localparam int c_ALU = 0, c_LOAD = 1, c_STORE = 2, c_BEQ = 3, c_JAL = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic imem_req, imem_ready;
    logic dmem_req, dmem_we, dmem_ready;
    logic dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
    logic alu_zero;
    logic ir_we, pc_we, pc_sel, rf_we;
    logic [2:0] state;
    logic fault;
    logic [c_ICNT_W-1:0] icount;

    cpu_seq_ctrl #(
        .TIMEOUT_W   (4),
        .MEM_TIMEOUT (c_TIMEOUT),
        .ICNT_W      (c_ICNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .dec_reg_write (dec_reg_write),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_branch    (dec_branch),
        .dec_jump      (dec_jump),
        .alu_zero      (alu_zero),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .rf_we         (rf_we),
        .state         (state),
        .fault         (fault),
        .icount        (icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  cyc;
        logic [2:0]          st;
        logic                ir, pc, sel, rf;
        logic [c_ICNT_W-1:0] ic;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  n_issued = 0;
    int  last_c0  = 0;
    int  fixed_op = -1, fixed_iw = -1, fixed_dw = -1;
    int  cur_iw = 0, cur_dw = 0, icnt = 0, dcnt = 0;
    logic cur_store = 1'b0;
    logic prev_ireq = 1'b0, prev_dreq = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] st, input logic ir,
                           input logic pc, input logic sel, input logic rf);
        ev_t e;
        e.cyc = c; e.st = st; e.ir = ir; e.pc = pc; e.sel = sel; e.rf = rf;
        e.ic  = c_ICNT_W'(n_issued);
        q.push_back(e);
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 7) == 0) ? (c_TIMEOUT - 1) : int'($urandom_range(0, 3));
    endfunction

    // ------------------------------------------------------------------
    // Driver: decoder + memory model + expected-event generator.
    // Cycle offsets from fetch start c0 with iw/dw wait cycles:
    //   ir_we at c0+iw, EXEC at c0+iw+2, MEM c0+iw+3 .. c0+iw+3+dw,
    //   WB at c0+iw+3 (ALU/JAL) or c0+iw+4+dw (load).
    // ------------------------------------------------------------------
    always begin
        @(posedge clk);
        #2;
        if (imem_req) begin
            if (!prev_ireq) begin
                int  op;
                logic rw, z;
                op = (fixed_op >= 0) ? fixed_op : int'($urandom_range(0, 4));
                cur_iw = (fixed_iw >= 0) ? fixed_iw : pick_wait();
                cur_dw = (fixed_dw >= 0) ? fixed_dw : pick_wait();
                rw = 1'($urandom_range(0, 1));
                z  = 1'($urandom_range(0, 1));
                dec_reg_write = rw;
                dec_mem_read  = (op == c_LOAD);
                dec_mem_write = (op == c_STORE);
                dec_branch    = (op == c_BEQ);
                dec_jump      = (op == c_JAL);
                alu_zero      = z;
                cur_store     = (op == c_STORE);
                icnt          = 0;
                last_c0       = cyc;
                if (cur_iw != c_NEVER) begin
                    push_ev(cyc + cur_iw, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
                    case (op)
                        c_ALU:   push_ev(cyc + cur_iw + 3, 3'd5, 1'b0, 1'b1, 1'b0, rw);
                        c_BEQ:   push_ev(cyc + cur_iw + 2, 3'd3, 1'b0, 1'b1, z, 1'b0);
                        c_JAL: begin
                            push_ev(cyc + cur_iw + 2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
                            if (rw) push_ev(cyc + cur_iw + 3, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
                        end
                        c_LOAD:  if (cur_dw != c_NEVER)
                                     push_ev(cyc + cur_iw + 4 + cur_dw, 3'd5, 1'b0, 1'b1, 1'b0, rw);
                        default: if (cur_dw != c_NEVER)
                                     push_ev(cyc + cur_iw + 3 + cur_dw, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
                    endcase
                end
                n_issued++;
            end else begin
                icnt++;
            end
            imem_ready = (icnt == cur_iw);
        end else begin
            imem_ready = 1'b0;
        end
        prev_ireq = imem_req;

        if (dmem_req) begin
            dcnt = prev_dreq ? dcnt + 1 : 0;
            dmem_ready = (dcnt == cur_dw);
        end else begin
            dmem_ready = 1'b0;
        end
        prev_dreq = dmem_req;
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req || dmem_req) begin
                chk("req_exclusive", {31'd0, imem_req & dmem_req}, 32'd0);
                if (dmem_req) chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur_store});
            end
            if (ir_we || pc_we || rf_we) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: st=%0d ir=%b pc=%b rf=%b cycle %0d expected none",
                             state, ir_we, pc_we, rf_we, cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.st != state || e.ir != ir_we || e.pc != pc_we ||
                        e.rf != rf_we || e.ic != icount || (e.pc && e.sel != pc_sel)) begin
                        failures++;
                        $display("FAIL strobe_event: got cyc=%0d st=%0d ir=%b pc=%b sel=%b rf=%b ic=%0d expected cyc=%0d st=%0d ir=%b pc=%b sel=%b rf=%b ic=%0d",
                                 cyc, state, ir_we, pc_we, pc_sel, rf_we, icount,
                                 e.cyc, e.st, e.ir, e.pc, e.sel, e.rf, e.ic);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state !== st && n < budget) begin
            step();
            n++;
        end
        if (state !== st) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: state=%0d required %0d", name, state, st);
        end
    endtask

    task automatic wait_issue(input string name);
        int start = n_issued;
        int n = 0;
        while (n_issued == start && n < 20) begin
            step();
            n++;
        end
        if (n_issued == start) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: no fetch started, required one", name);
        end
    endtask

    // One instruction to completion, then park in IDLE.
    task automatic run_one(input int op, input int iw, input int dw, input string name);
        fixed_op = op; fixed_iw = iw; fixed_dw = dw;
        run = 1'b1;
        wait_issue(name);
        run = 1'b0;
        wait_state(3'd0, 60, name);
        chk({name, "_nofault"}, {31'd0, fault}, 32'd0);
        chk({name, "_drained"}, q.size(), 32'd0);
        chk({name, "_icount"}, {28'd0, icount}, {28'd0, 4'(n_issued)});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        q.delete();
        n_issued = 0;
        run = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
        dec_branch = 1'b0; dec_jump = 1'b0; alu_zero = 1'b0;
        #12;
        chk("reset_state",  {29'd0, state}, 32'd0);
        chk("reset_fault",  {31'd0, fault}, 32'd0);
        chk("reset_icount", {28'd0, icount}, 32'd0);
        chk("reset_strobes", {28'd0, ir_we, pc_we, rf_we, imem_req | dmem_req}, 32'd0);
        rst_n = 1'b1;

        // Random instruction stream; icount wraps several times.
        run = 1'b1;
        begin
            int n = 0;
            while (n_issued < c_N_RAND && n < 5000) begin
                step();
                n++;
            end
        end
        run = 1'b0;
        wait_state(3'd0, 60, "rand_park");
        chk("rand_drained", q.size(), 32'd0);
        chk("rand_icount", {28'd0, icount}, {28'd0, 4'(n_issued)});

        // run dropped during EXEC: WB completes, then IDLE.
        fixed_op = c_ALU; fixed_iw = 0; fixed_dw = 0;
        run = 1'b1;
        wait_state(3'd3, 20, "exec");
        run = 1'b0;
        step();
        chk("rundrop_wb", {29'd0, state}, 32'd5);
        step();
        chk("rundrop_idle", {29'd0, state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rundrop_parked", {28'd0, state, imem_req}, 32'd0);
        end

        // Ready on the last allowed wait cycle wins over the timeout.
        run_one(c_ALU,  c_TIMEOUT - 1, 0, "fetch_edge");
        run_one(c_LOAD, 0, c_TIMEOUT - 1, "load_edge");
        run_one(c_STORE, 1, 3, "store");

        // Asynchronous reset in the middle of MEM.
        fixed_op = c_LOAD; fixed_iw = 0; fixed_dw = c_NEVER;
        run = 1'b1;
        begin
            int n = 0;
            while (!dmem_req && n < 20) begin
                step();
                n++;
            end
        end
        step();
        step();
        chk("midmem_before", {29'd0, state}, 32'd4);
        do_reset();
        chk("midmem_state",  {29'd0, state}, 32'd0);
        chk("midmem_dreq",   {31'd0, dmem_req}, 32'd0);
        chk("midmem_icount", {28'd0, icount}, 32'd0);
        #3 rst_n = 1'b1;
        run_one(c_ALU, 0, 0, "post_reset");

        // Instruction memory never ready: FAULT after MEM_TIMEOUT cycles.
        fixed_op = c_ALU; fixed_iw = c_NEVER; fixed_dw = 0;
        run = 1'b1;
        wait_issue("fault_fetch");
        wait_state(3'd6, 40, "fault");
        chk("fault_cycle", cyc, last_c0 + c_TIMEOUT);
        chk("fault_flag", {31'd0, fault}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fault_sticky", {25'd0, state, fault, ir_we, pc_we, rf_we, imem_req | dmem_req},
                {25'd0, 3'd6, 1'b1, 4'd0});
        end
        do_reset();
        chk("fault_cleared", {28'd0, state, fault}, 32'd0);
        #3 rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_seq_ctrl
`default_nettype wire
